// File: rtl/fade_pkg.sv
// Shared constants and segment-table helpers for the RGB colour-wheel fade scheduler.
package fade_pkg;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    SEG_0 = 3'd0,
    SEG_1 = 3'd1,
    SEG_2 = 3'd2,
    SEG_3 = 3'd3,
    SEG_4 = 3'd4,
    SEG_5 = 3'd5
  } seg_e;

  // Wheel order: G up, R down, B up, G down, R up, B down.
  function automatic logic [1:0] seg_ramp_ch(input seg_e seg);
    case (seg)
      SEG_0, SEG_3: return CH_G;
      SEG_1, SEG_4: return CH_R;
      default:      return CH_B;
    endcase
  endfunction

  function automatic logic seg_ramp_dir(input seg_e seg);
    case (seg)
      SEG_0, SEG_2, SEG_4: return DIR_UP;
      default:             return DIR_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/fade_scheduler_pwm_compare.sv
// One free-running PWM counter shared by three registered duty comparators.
module pwm_compare #(
  parameter int PWM_INTERVAL = 600,
  parameter int DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_duty_r,
  input  logic [DW-1:0] i_duty_g,
  input  logic [DW-1:0] i_duty_b,
  output logic          o_pwm_r,
  output logic          o_pwm_g,
  output logic          o_pwm_b
);

  localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_ext;
  logic          r_pwm_r;
  logic          r_pwm_g;
  logic          r_pwm_b;

  assign w_cnt_ext = DW'(r_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pwm_r <= 1'b0;
      r_pwm_g <= 1'b0;
      r_pwm_b <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_pwm_r <= (w_cnt_ext < i_duty_r);
      r_pwm_g <= (w_cnt_ext < i_duty_g);
      r_pwm_b <= (w_cnt_ext < i_duty_b);
    end
  end

  assign o_pwm_r = r_pwm_r;
  assign o_pwm_g = r_pwm_g;
  assign o_pwm_b = r_pwm_b;

endmodule

// File: rtl/fade_scheduler.sv
// RGB colour-wheel scheduler: one prescaler ramps one channel per segment over six segments.
module fade_scheduler
  import fade_pkg::*;
#(
  parameter int CLK_TICKS_PER_STEP = 10000,
  parameter int STEPS_PER_SEG      = 200,
  parameter int PWM_INTERVAL       = 600,
  parameter int DW                 = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          restart,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [2:0]    seg,
  output logic          seg_done,
  output logic          pwm_r,
  output logic          pwm_g,
  output logic          pwm_b
);

  localparam int STEP_VAL = PWM_INTERVAL / STEPS_PER_SEG;
  localparam int PW = (CLK_TICKS_PER_STEP > 1) ? $clog2(CLK_TICKS_PER_STEP) : 1;
  localparam int SW = (STEPS_PER_SEG > 1) ? $clog2(STEPS_PER_SEG) : 1;
  localparam int AW = DW + 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_TICKS_PER_STEP - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_SEG - 1);
  localparam logic [AW-1:0] A_MAX      = AW'(PWM_INTERVAL);
  localparam logic [AW-1:0] A_STEP     = AW'(STEP_VAL);
  localparam logic [DW-1:0] D_MAX      = DW'(PWM_INTERVAL);

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_step;
  logic [DW-1:0] r_duty_r;
  logic [DW-1:0] r_duty_g;
  logic [DW-1:0] r_duty_b;
  seg_e          r_seg;
  logic          r_seg_done;

  logic          w_tick;
  logic          w_last;
  logic [1:0]    w_ch;
  logic          w_dir;
  logic [AW-1:0] w_cur;
  logic [AW-1:0] w_sum;
  logic [DW-1:0] w_ramp;
  logic [DW-1:0] w_duty_r_nxt;
  logic [DW-1:0] w_duty_g_nxt;
  logic [DW-1:0] w_duty_b_nxt;
  seg_e          w_seg_nxt;
  logic          w_seg_done_nxt;

  assign w_tick = en && (r_presc == PRESC_LAST);
  assign w_last = (r_step == STEP_LAST);
  assign w_ch   = seg_ramp_ch(r_seg);
  assign w_dir  = seg_ramp_dir(r_seg);

  // Arithmetic is one bit wider than the duty so the up-step cannot wrap before saturation.
  always_comb begin
    w_cur = '0;
    case (w_ch)
      CH_R:    w_cur = {1'b0, r_duty_r};
      CH_G:    w_cur = {1'b0, r_duty_g};
      default: w_cur = {1'b0, r_duty_b};
    endcase
    w_sum  = w_cur + A_STEP;
    w_ramp = '0;
    if (w_last)
      w_ramp = (w_dir == DIR_UP) ? D_MAX : '0;
    else if (w_dir == DIR_UP)
      w_ramp = (w_sum > A_MAX) ? D_MAX : DW'(w_sum);
    else
      w_ramp = (w_cur < A_STEP) ? '0 : DW'(w_cur - A_STEP);
  end

  always_comb begin
    w_duty_r_nxt = r_duty_r;
    w_duty_g_nxt = r_duty_g;
    w_duty_b_nxt = r_duty_b;
    if (w_tick) begin
      case (w_ch)
        CH_R:    w_duty_r_nxt = w_ramp;
        CH_G:    w_duty_g_nxt = w_ramp;
        default: w_duty_b_nxt = w_ramp;
      endcase
    end
  end

  // Segment FSM: restart wins over a segment-ending tick.
  always_comb begin
    w_seg_nxt      = r_seg;
    w_seg_done_nxt = 1'b0;
    if (restart) begin
      w_seg_nxt = SEG_0;
    end else if (w_tick && w_last) begin
      w_seg_done_nxt = 1'b1;
      case (r_seg)
        SEG_0:   w_seg_nxt = SEG_1;
        SEG_1:   w_seg_nxt = SEG_2;
        SEG_2:   w_seg_nxt = SEG_3;
        SEG_3:   w_seg_nxt = SEG_4;
        SEG_4:   w_seg_nxt = SEG_5;
        default: w_seg_nxt = SEG_0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= SEG_0;
      r_seg_done <= 1'b0;
    end else begin
      r_seg      <= w_seg_nxt;
      r_seg_done <= w_seg_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_step   <= '0;
      r_duty_r <= D_MAX;
      r_duty_g <= '0;
      r_duty_b <= '0;
    end else if (restart) begin
      r_presc  <= '0;
      r_step   <= '0;
      r_duty_r <= D_MAX;
      r_duty_g <= '0;
      r_duty_b <= '0;
    end else if (en) begin
      r_presc  <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick)
        r_step <= w_last ? '0 : r_step + 1'b1;
      r_duty_r <= w_duty_r_nxt;
      r_duty_g <= w_duty_g_nxt;
      r_duty_b <= w_duty_b_nxt;
    end
  end

  pwm_compare #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .DW           (DW)
  ) u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_duty_r (r_duty_r),
    .i_duty_g (r_duty_g),
    .i_duty_b (r_duty_b),
    .o_pwm_r  (pwm_r),
    .o_pwm_g  (pwm_g),
    .o_pwm_b  (pwm_b)
  );

  assign duty_r   = r_duty_r;
  assign duty_g   = r_duty_g;
  assign duty_b   = r_duty_b;
  assign seg      = r_seg;
  assign seg_done = r_seg_done;

endmodule

// File: tb/tb_fade_scheduler.sv
// Directed bench for fade_scheduler: small wheel (4 clocks/step, 4 steps/segment, max duty 12).
module tb_fade_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic restart;

  logic [3:0] duty_r, duty_g, duty_b;
  logic [2:0] seg;
  logic       seg_done, pwm_r, pwm_g, pwm_b;

  logic [3:0] b_duty_r, b_duty_g, b_duty_b;
  logic [2:0] b_seg;
  logic       b_seg_done, b_pwm_r, b_pwm_g, b_pwm_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fade_scheduler #(
    .CLK_TICKS_PER_STEP (4),
    .STEPS_PER_SEG      (4),
    .PWM_INTERVAL       (12)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (restart),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .seg      (seg),
    .seg_done (seg_done),
    .pwm_r    (pwm_r),
    .pwm_g    (pwm_g),
    .pwm_b    (pwm_b)
  );

  // Second instance with max duty 10: step value 2 truncates, so the last step is forced.
  fade_scheduler #(
    .CLK_TICKS_PER_STEP (4),
    .STEPS_PER_SEG      (4),
    .PWM_INTERVAL       (10)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (restart),
    .duty_r   (b_duty_r),
    .duty_g   (b_duty_g),
    .duty_b   (b_duty_b),
    .seg      (b_seg),
    .seg_done (b_seg_done),
    .pwm_r    (b_pwm_r),
    .pwm_g    (b_pwm_g),
    .pwm_b    (b_pwm_b)
  );

  typedef struct {
    int cyc;
    int r;
    int g;
    int b;
    int seg;
    int done;
    int gb;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_state(input string tag, input int r, input int g, input int b,
                           input int s, input int d);
    chk($sformatf("%s_duty_r", tag), int'(duty_r), r);
    chk($sformatf("%s_duty_g", tag), int'(duty_g), g);
    chk($sformatf("%s_duty_b", tag), int'(duty_b), b);
    chk($sformatf("%s_seg", tag), int'(seg), s);
    chk($sformatf("%s_seg_done", tag), int'(seg_done), d);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut(input logic en_v);
    rst_n   = 1'b0;
    restart = 1'b0;
    en      = en_v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_pulse;
    int n_high;

    tbl[0]  = '{3,  12, 0,  0,  0, 0, 0};
    tbl[1]  = '{4,  12, 3,  0,  0, 0, 2};
    tbl[2]  = '{8,  12, 6,  0,  0, 0, 4};
    tbl[3]  = '{12, 12, 9,  0,  0, 0, 6};
    tbl[4]  = '{16, 12, 12, 0,  1, 1, 10};
    tbl[5]  = '{17, 12, 12, 0,  1, 0, -1};
    tbl[6]  = '{20, 9,  12, 0,  1, 0, -1};
    tbl[7]  = '{32, 0,  12, 0,  2, 1, -1};
    tbl[8]  = '{36, 0,  12, 3,  2, 0, -1};
    tbl[9]  = '{48, 0,  12, 12, 3, 1, -1};
    tbl[10] = '{52, 0,  9,  12, 3, 0, -1};
    tbl[11] = '{64, 0,  0,  12, 4, 1, -1};
    tbl[12] = '{68, 3,  0,  12, 4, 0, -1};
    tbl[13] = '{80, 12, 0,  12, 5, 1, -1};
    tbl[14] = '{88, 12, 0,  6,  5, 0, -1};
    tbl[15] = '{96, 12, 0,  0,  0, 1, -1};
    tbl[16] = '{97, 12, 0,  0,  0, 0, -1};

    rst_n   = 1'b0;
    en      = 1'b0;
    restart = 1'b0;
    #12;
    chk_state("in_reset", 12, 0, 0, 0, 0);
    chk("in_reset_pwm_r", int'(pwm_r), 0);
    chk("in_reset_pwm_g", int'(pwm_g), 0);
    chk("in_reset_pwm_b", int'(pwm_b), 0);

    // Full wheel from reset, checked at segment endpoints and intermediate steps.
    reset_dut(1'b1);
    n_pulse = 0;
    for (int i = 0; i < 17; i++) begin
      while (cyc < tbl[i].cyc) begin
        step_clk();
        if (seg_done) n_pulse++;
      end
      chk_state($sformatf("wheel_c%0d", tbl[i].cyc), tbl[i].r, tbl[i].g, tbl[i].b,
                tbl[i].seg, tbl[i].done);
      if (tbl[i].gb >= 0)
        chk($sformatf("trunc_g_c%0d", tbl[i].cyc), int'(b_duty_g), tbl[i].gb);
    end
    chk("wheel_seg_done_pulses", n_pulse, 6);

    // Freeze with en low mid segment 2; the prescaler must resume where it stopped.
    reset_dut(1'b1);
    while (cyc < 34) step_clk();
    chk_state("pre_freeze", 0, 12, 0, 2, 0);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      chk_state($sformatf("frozen_%0d", i), 0, 12, 0, 2, 0);
    end
    en = 1'b1;
    step_clk();
    chk("resume_before_tick_b", int'(duty_b), 0);
    step_clk();
    chk("resume_tick_b", int'(duty_b), 3);
    en = 1'b0;
    repeat (3) step_clk();
    chk("short_freeze_b", int'(duty_b), 3);
    en = 1'b1;
    repeat (3) step_clk();
    chk("short_resume_pre_b", int'(duty_b), 3);
    step_clk();
    chk("short_resume_tick_b", int'(duty_b), 6);

    // Restart on the segment-ending tick, then asynchronous reset mid-ramp.
    reset_dut(1'b1);
    while (cyc < 15) step_clk();
    chk_state("pre_restart", 12, 9, 0, 0, 0);
    restart = 1'b1;
    step_clk();
    restart = 1'b0;
    chk_state("restart", 12, 0, 0, 0, 0);
    step_clk();
    chk_state("restart_next", 12, 0, 0, 0, 0);
    repeat (2) step_clk();
    chk("restart_pre_tick_g", int'(duty_g), 0);
    step_clk();
    chk("restart_tick_g", int'(duty_g), 3);
    repeat (2) step_clk();
    chk("pre_async_pwm_r", int'(pwm_r), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 12, 0, 0, 0, 0);
    chk("async_rst_pwm_r", int'(pwm_r), 0);
    chk("async_rst_pwm_g", int'(pwm_g), 0);
    chk("async_rst_pwm_b", int'(pwm_b), 0);

    // Hold at segment 2 midpoint (R=0, G=12, B=6) and watch the PWM pins.
    reset_dut(1'b1);
    while (cyc < 40) step_clk();
    chk_state("pwm_hold", 0, 12, 6, 2, 0);
    en = 1'b0;
    n_high = 0;
    for (int i = 0; i < 24; i++) begin
      step_clk();
      chk($sformatf("pwm_r_c%0d", cyc), int'(pwm_r), 0);
      chk($sformatf("pwm_g_c%0d", cyc), int'(pwm_g), 1);
      chk($sformatf("pwm_b_c%0d", cyc), int'(pwm_b), int'(((cyc - 1) % 12) < 6));
      if (pwm_b) n_high++;
    end
    chk("pwm_b_high_count", n_high, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
